// File: rtl/awgn_pkg.sv
// Shared constants, request type and exponent range check for the AWGN y_f shifter.
package awgn_pkg;

   localparam int DW      = 20;
   localparam int EW      = 5;
   localparam int OW      = 23;
   localparam int EXP_MIN = -12;
   localparam int EXP_MAX = 3;

   typedef struct packed {
      logic [DW-1:0] y_f;
      logic [EW-1:0] exp;
      logic          tag;
   } shift_req_t;

   function automatic logic exp_out_of_range(input logic [EW-1:0] e);
      int v;
      v = int'($signed(e));
      return (v < EXP_MIN) || (v > EXP_MAX);
   endfunction

endpackage

// File: rtl/awgn_shift_sched_shiftery.sv
// Combinational y_f shifter core: left by 0..3, right by 1..16 with zero fill.
module shiftery_f
   import awgn_pkg::*;
(
   input  logic [DW-1:0] y_f,
   input  logic [EW-1:0] exp,
   output logic [OW-1:0] ff
);

   logic [OW-1:0] ext_s;
   logic [EW-1:0] neg_s;

   assign ext_s = {3'b000, y_f};
   assign neg_s = 5'd0 - exp;

   // Direction chosen by exponent sign; out-of-range codes are masked by the caller.
   always_comb begin
      ff = ext_s;
      if (exp[EW-1] == 1'b0) begin
         ff = ext_s << exp[1:0];
      end else begin
         ff = ext_s >> neg_s;
      end
   end

endmodule

// File: rtl/awgn_shift_sched.sv
// Two-requester arbiter feeding one shared y_f shifter through a 2-stage registered pipeline.
module awgn_shift_sched
   import awgn_pkg::*;
#(
   parameter bit RR_EN = 1'b1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [19:0]   req0_y_f,
   input  logic [4:0]    req0_exp,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [19:0]   req1_y_f,
   input  logic [4:0]    req1_exp,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [22:0]   out_ff,
   output logic          out_tag,
   output logic          out_err,
   output logic          busy
);

   logic          last_grant_r;
   logic          s1_valid_r;
   shift_req_t    s1_req_r;
   logic          s2_valid_r;
   logic [OW-1:0] out_ff_r;
   logic          out_tag_r;
   logic          out_err_r;

   logic          grant0_s;
   logic          grant1_s;
   logic          s2_load_s;
   logic          s1_room_s;
   logic          s1_load_s;
   shift_req_t    new_req_s;
   logic [OW-1:0] core_ff_s;
   logic          err_s;
   logic [OW-1:0] shifted_s;

   // Grant selection; last_grant_r = 1 means requester 1 was served last.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (req0_valid && req1_valid) begin
         if (RR_EN) begin
            if (last_grant_r) begin
               grant0_s = 1'b1;
            end else begin
               grant1_s = 1'b1;
            end
         end else begin
            grant0_s = 1'b1;
         end
      end else if (req0_valid) begin
         grant0_s = 1'b1;
      end else if (req1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   assign s2_load_s  = s1_valid_r & (~s2_valid_r | out_ready);
   assign s1_room_s  = ~s1_valid_r | s2_load_s;
   assign req0_ready = grant0_s & s1_room_s;
   assign req1_ready = grant1_s & s1_room_s;
   assign s1_load_s  = req0_ready | req1_ready;

   // Capture mux for the granted requester.
   always_comb begin
      new_req_s.y_f = req0_y_f;
      new_req_s.exp = req0_exp;
      new_req_s.tag = 1'b0;
      if (grant1_s) begin
         new_req_s.y_f = req1_y_f;
         new_req_s.exp = req1_exp;
         new_req_s.tag = 1'b1;
      end else begin
         new_req_s.tag = 1'b0;
      end
   end

   shiftery_f u_core (
      .y_f (s1_req_r.y_f),
      .exp (s1_req_r.exp),
      .ff  (core_ff_s)
   );

   assign err_s     = exp_out_of_range(s1_req_r.exp);
   assign shifted_s = err_s ? {3'b000, s1_req_r.y_f} : core_ff_s;

   // Round-robin history, advanced only on a completed handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_r <= 1'b1;
      end else if (s1_load_s) begin
         last_grant_r <= req1_ready;
      end
   end

   // Stage 1: captured request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_req_r   <= '0;
      end else if (s1_load_s) begin
         s1_valid_r <= 1'b1;
         s1_req_r   <= new_req_s;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2: output register, held while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_r <= 1'b0;
         out_ff_r   <= '0;
         out_tag_r  <= 1'b0;
         out_err_r  <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= 1'b1;
         out_ff_r   <= shifted_s;
         out_tag_r  <= s1_req_r.tag;
         out_err_r  <= err_s;
      end else if (out_ready) begin
         s2_valid_r <= 1'b0;
      end
   end

   assign out_valid = s2_valid_r;
   assign out_ff    = out_ff_r;
   assign out_tag   = out_tag_r;
   assign out_err   = out_err_r;
   assign busy      = s1_valid_r | s2_valid_r;

endmodule

// File: tb/tb_awgn_shift_sched.sv
// Bench for awgn_shift_sched: occupancy-level reference model plus directed literal checks.
module tb_awgn_shift_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0v, r1v, ordy;
   logic [19:0] r0y, r1y;
   logic [4:0]  r0e, r1e;

   logic        r0rdy, r1rdy, ov, otag, oerr, busy;
   logic [22:0] off;
   logic        f_r0rdy, f_r1rdy, f_ov, f_otag, f_oerr, f_busy;
   logic [22:0] f_off;

   always #5 clk = ~clk;

   awgn_shift_sched #(.RR_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(r0v), .req0_ready(r0rdy), .req0_y_f(r0y), .req0_exp(r0e),
      .req1_valid(r1v), .req1_ready(r1rdy), .req1_y_f(r1y), .req1_exp(r1e),
      .out_valid(ov), .out_ready(ordy), .out_ff(off), .out_tag(otag),
      .out_err(oerr), .busy(busy)
   );

   awgn_shift_sched #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset(reset),
      .req0_valid(r0v), .req0_ready(f_r0rdy), .req0_y_f(r0y), .req0_exp(r0e),
      .req1_valid(r1v), .req1_ready(f_r1rdy), .req1_y_f(r1y), .req1_exp(r1e),
      .out_valid(f_ov), .out_ready(ordy), .out_ff(f_off), .out_tag(f_otag),
      .out_err(f_oerr), .busy(f_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Returns {err, ff} straight from the shift rules.
   function automatic logic [23:0] ref_shift(input logic [19:0] y, input logic [4:0] e);
      int s;
      logic [22:0] w;
      s = $signed(e);
      w = {3'b000, y};
      if (s > 3 || s < -12) return {1'b1, w};
      else if (s >= 0)      return {1'b0, w << s};
      else                  return {1'b0, w >> (-s)};
   endfunction

   typedef struct {
      logic [22:0] ff;
      logic        tag;
      logic        err;
      int          acc;
   } item_t;

   item_t q[$];
   item_t p_item;
   int    cyc = 0;
   logic  m_last = 1'b1;
   logic  p_last;
   bit    p_push = 1'b0;
   bit    p_pop = 1'b0;

   // Reference model compare: at most two words in flight, a word is visible one edge after acceptance.
   always @(negedge clk) begin : model_cmp
      int n;
      logic g0, g1, room, ev;
      logic [23:0] r;
      if (reset) begin
         q.delete();
         m_last = 1'b1;
         p_push = 1'b0;
         p_pop  = 1'b0;
      end else begin
         n = q.size();
         g0 = 1'b0;
         g1 = 1'b0;
         if (r0v && r1v) begin
            if (m_last) g0 = 1'b1; else g1 = 1'b1;
         end else if (r0v) g0 = 1'b1;
         else if (r1v) g1 = 1'b1;
         room = (n < 2) || ordy;
         chk("m_req0_ready", r0rdy, g0 && room);
         chk("m_req1_ready", r1rdy, g1 && room);
         ev = (n > 0) && (cyc - q[0].acc >= 1);
         chk("m_out_valid", ov, ev);
         if (ev) begin
            chk("m_out_ff", off, q[0].ff);
            chk("m_out_tag", otag, q[0].tag);
            chk("m_out_err", oerr, q[0].err);
         end
         chk("m_busy", busy, n > 0);
         p_pop  = ev && ordy;
         p_push = (g0 || g1) && room;
         if (p_push) begin
            r = g1 ? ref_shift(r1y, r1e) : ref_shift(r0y, r0e);
            p_item.ff  = r[22:0];
            p_item.err = r[23];
            p_item.tag = g1;
            p_last     = g1;
         end
      end
   end

   // Reference model state advance on the clock edge.
   always @(posedge clk) begin : model_upd
      cyc++;
      if (!reset) begin
         if (p_pop) void'(q.pop_front());
         if (p_push) begin
            p_item.acc = cyc;
            q.push_back(p_item);
            m_last = p_last;
         end
      end
      p_push = 1'b0;
      p_pop  = 1'b0;
   end

   task automatic idle();
      r0v = 1'b0; r1v = 1'b0; ordy = 1'b1;
      r0y = 20'h0; r1y = 20'h0; r0e = 5'b00000; r1e = 5'b00000;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Single requester-0 word with literal expectation and one-edge-after-accept latency.
   task automatic send0(input string name, input logic [19:0] y, input logic [4:0] e,
                        input logic [22:0] exp_ff, input logic exp_err);
      bit got;
      got = 1'b0;
      r0v = 1'b1; r0y = y; r0e = e; r1v = 1'b0; ordy = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (r0rdy) got = 1'b1;
      end
      chk({name, "_accepted"}, got, 1'b1);
      @(posedge clk); #1;
      r0v = 1'b0;
      @(negedge clk);
      chk({name, "_not_yet"}, ov, 1'b0);
      @(negedge clk);
      chk({name, "_valid"}, ov, 1'b1);
      chk({name, "_ff"}, off, exp_ff);
      chk({name, "_tag"}, otag, 1'b0);
      chk({name, "_err"}, oerr, exp_err);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : stim
      int k, fk, acc_cnt, ntx;
      bit a0, a1;
      reset = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // 1: reset mid-stream
      r0v = 1'b1; r0y = 20'h11111; r0e = 5'b00001;
      r1v = 1'b1; r1y = 20'h22222; r1e = 5'b00010;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rst_out_valid", ov, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_ff", off, 23'h000000);
      chk("rst_out_tag", otag, 1'b0);
      chk("rst_out_err", oerr, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_first_req0", r0rdy, 1'b1);
      chk("rst_first_req1", r1rdy, 1'b0);
      @(posedge clk); #1;
      idle();
      repeat (4) @(posedge clk);
      #1;

      // 2: single req0 words
      send0("t2a", 20'h00001, 5'b00011, 23'h000008, 1'b0);
      send0("t2b", 20'hFFFFF, 5'b10100, 23'h0000FF, 1'b0);
      send0("t2c", 20'hFFFFF, 5'b11111, 23'h07FFFF, 1'b0);
      // 5: out-of-range exponents
      send0("t5a", 20'hABCDE, 5'b10011, 23'h0ABCDE, 1'b1);
      send0("t5b", 20'hABCDE, 5'b00100, 23'h0ABCDE, 1'b1);

      // 3: continuous contention, round robin vs fixed priority
      do_reset();
      r0v = 1'b1; r0y = 20'h00010; r0e = 5'b00001;
      r1v = 1'b1; r1y = 20'h00020; r1e = 5'b11111;
      ordy = 1'b1;
      k = 0; fk = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ov && k < 8) begin
            chk("rr_tag_seq", otag, k[0]);
            k++;
         end
         chk("fp_req1_ready", f_r1rdy, 1'b0);
         if (f_ov) begin
            chk("fp_tag", f_otag, 1'b0);
            fk++;
         end
      end
      chk("rr_word_count", k, 8);
      chk("fp_enough_words", fk >= 8, 1'b1);
      @(posedge clk); #1;

      // 4: output stall with both requesters valid
      do_reset();
      r0v = 1'b1; r0y = 20'h12345; r0e = 5'b00001;
      r1v = 1'b1; r1y = 20'h00F00; r1e = 5'b11100;
      ordy = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (r0rdy || r1rdy) acc_cnt++;
         if (ov) begin
            chk("stall_ff", off, 23'h02468A);
            chk("stall_tag", otag, 1'b0);
         end
      end
      chk("stall_accepts", acc_cnt, 2);
      chk("stall_held_valid", ov, 1'b1);
      @(posedge clk); #1;
      ordy = 1'b1;
      @(negedge clk);
      chk("release_ff", off, 23'h02468A);
      @(negedge clk);
      chk("release_next_ff", off, 23'h0000F0);
      chk("release_next_tag", otag, 1'b1);
      @(posedge clk); #1;
      idle();
      repeat (4) @(posedge clk);
      #1;

      // 6: random traffic, holding offered data until accepted
      ntx = 0;
      for (int c = 0; c < 60000 && ntx < 10000; c++) begin
         @(negedge clk);
         a0 = r0v & r0rdy;
         a1 = r1v & r1rdy;
         if (a0 || a1) ntx++;
         @(posedge clk); #1;
         if (!r0v || a0) begin
            r0v = ($urandom_range(0, 9) < 7);
            r0y = 20'($urandom);
            r0e = 5'($urandom_range(0, 31));
         end
         if (!r1v || a1) begin
            r1v = ($urandom_range(0, 9) < 7);
            r1y = 20'($urandom);
            r1e = 5'($urandom_range(0, 31));
         end
         ordy = ($urandom_range(0, 3) != 0);
      end
      chk("rand_tx_done", ntx >= 10000, 1'b1);
      r0v = 1'b0; r1v = 1'b0; ordy = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("drain_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
